// File: rtl/sia_miner_core.sv
// sia_miner_core: BLAKE2b-256 Sia header nonce search, one G function per cycle.
// Define SIACORE_HASHCNT_EN to add the hash_cnt completed-hash counter output.
module sia_miner_core #(
  parameter int ROUNDS = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [639:0] work,
  input  logic [63:0]  target,
  input  logic         valid,
  output logic         busy,
  output logic         found,
  output logic [31:0]  nonce
`ifdef SIACORE_HASHCNT_EN
  ,
  output logic [31:0]  hash_cnt
`endif
);

  localparam logic [7:0][63:0] IV = {
    64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b,
    64'h9b05688c2b3e6c1f, 64'h510e527fade682d1,
    64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b,
    64'hbb67ae8584caa73b, 64'h6a09e667f3bcc908
  };
  localparam logic [63:0] H0 = IV[0] ^ 64'h0101_0020;

  localparam logic [9:0][63:0] SIGMA = {
    64'ha2847615fb9e3cd0, 64'h6fe9b308c2d714a5,
    64'hdb7ec13950f4862a, 64'hc51fed4a0763928b,
    64'h2c6a0b834d75fe19, 64'h905724afe1bc683d,
    64'h7931dcbe265a40f8, 64'hb8c052fdae367194,
    64'hea489fd61c02b753, 64'h0123456789abcdef
  };

  typedef enum logic [1:0] {IDLE, INIT, ROUND, CHECK} state_t;

  function automatic logic [63:0] bswap64(input logic [63:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24],
            x[39:32], x[47:40], x[55:48], x[63:56]};
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // hdr holds m0..m3, m5..m9; word 4 lives in the m04 counter register
  function automatic logic [63:0] msg(
    input logic [3:0]       i,
    input logic [8:0][63:0] h,
    input logic [63:0]      m4
  );
    logic [63:0] r;
    r = '0;
    unique case (1'b1)
      (i < 4'd4):                r = h[i];
      (i == 4'd4):               r = m4;
      (i > 4'd4 && i < 4'd10):   r = h[i - 4'd1];
      (i >= 4'd10):              r = '0;
    endcase
    return r;
  endfunction

  state_t state, nstate;
  logic [8:0][63:0]  hdr;
  logic [63:0]       tgt;
  logic [63:0]       m04;
  logic [15:0][63:0] v;
  logic [3:0]        rnd;
  logic [2:0]        gstep;
  logic [3:0]        srow;

  logic [3:0]  ia, ib, ic, id, sx, sy;
  logic [63:0] row, mx, my, t;
  logic [63:0] a1, b1, c1, d1, a2, b2, c2, d2;
  logic [63:0] hval;
  logic        hit, wrapped, last_g;

  always_comb begin
    ia = {2'b00, gstep[1:0]};
    ib = {2'b01, gstep[1:0]};
    ic = {2'b10, gstep[1:0]};
    id = {2'b11, gstep[1:0]};
    if (gstep[2]) begin
      ib = {2'b01, gstep[1:0] + 2'd1};
      ic = {2'b10, gstep[1:0] + 2'd2};
      id = {2'b11, gstep[1:0] + 2'd3};
    end
    row = SIGMA[srow];
    sx = row[6'd60 - {gstep, 3'b000} +: 4];
    sy = row[6'd56 - {gstep, 3'b000} +: 4];
    mx = msg(sx, hdr, m04);
    my = msg(sy, hdr, m04);
    a1 = v[ia] + v[ib] + mx;
    t  = v[id] ^ a1;
    d1 = {t[31:0], t[63:32]};
    c1 = v[ic] + d1;
    t  = v[ib] ^ c1;
    b1 = {t[23:0], t[63:24]};
    a2 = a1 + b1 + my;
    t  = d1 ^ a2;
    d2 = {t[15:0], t[63:16]};
    c2 = c1 + d2;
    t  = b1 ^ c2;
    b2 = {t[62:0], t[63]};
  end

  assign hval    = bswap64(H0 ^ v[0] ^ v[8]);
  assign hit     = hval < tgt;
  assign wrapped = m04[31:0] == 32'hFFFF_FFFF;
  assign last_g  = (gstep == 3'd7) && (rnd == 4'(ROUNDS - 1));
  assign busy    = state != IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (valid) nstate = INIT;
      INIT:  nstate = ROUND;
      ROUND: if (last_g) nstate = CHECK;
      CHECK: nstate = (hit || wrapped) ? IDLE : INIT;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr   <= '0;
      tgt   <= '0;
      m04   <= '0;
      v     <= '0;
      rnd   <= '0;
      gstep <= '0;
      srow  <= '0;
      found <= 1'b0;
      nonce <= '0;
    end else begin
      found <= 1'b0;
      unique case (state)
        IDLE: if (valid) begin
          hdr <= {bswap64(work[63:0]),    bswap64(work[127:64]),
                  bswap64(work[191:128]), bswap64(work[255:192]),
                  bswap64(work[319:256]), bswap64(work[447:384]),
                  bswap64(work[511:448]), bswap64(work[575:512]),
                  bswap64(work[639:576])};
          tgt <= target;
          m04 <= bswap64(work[383:320]);
        end
        INIT: begin
          // t=80 folded into v12, final-block flag inverts v14
          v <= {IV[7], ~IV[6], IV[5], IV[4] ^ 64'd80,
                IV[3:0], IV[7:1], H0};
          rnd   <= '0;
          gstep <= '0;
          srow  <= '0;
        end
        ROUND: begin
          v[ia] <= a2;
          v[ib] <= b2;
          v[ic] <= c2;
          v[id] <= d2;
          gstep <= gstep + 3'd1;
          if (gstep == 3'd7) begin
            rnd  <= rnd + 4'd1;
            srow <= (srow == 4'd9) ? 4'd0 : srow + 4'd1;
          end
        end
        CHECK: begin
          if (hit) begin
            found <= 1'b1;
            nonce <= bswap32(m04[31:0]);
          end else begin
            m04[31:0] <= m04[31:0] + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SIACORE_HASHCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              hash_cnt <= '0;
    else if (state == CHECK) hash_cnt <= hash_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sia_miner_core.sv
// tb_sia_miner_core: randomized nonce-search checks against a plain BLAKE2b model.
`timescale 1ns/1ps
module tb_sia_miner_core;
  localparam int ROUNDS = 12;
  localparam int LAT = 2 + ROUNDS * 8;

  localparam logic [63:0] IVT [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
    64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
    64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

  localparam int SIG [10][16] = '{
    '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
    '{14, 10, 4, 8, 9, 15, 13, 6, 1, 12, 0, 2, 11, 7, 5, 3},
    '{11, 8, 12, 0, 5, 2, 15, 13, 10, 14, 3, 6, 7, 1, 9, 4},
    '{7, 9, 3, 1, 13, 12, 11, 14, 2, 6, 5, 10, 4, 0, 15, 8},
    '{9, 0, 5, 7, 2, 4, 10, 15, 14, 1, 11, 12, 6, 8, 3, 13},
    '{2, 12, 6, 10, 0, 11, 8, 3, 4, 13, 7, 5, 15, 14, 1, 9},
    '{12, 5, 1, 15, 14, 13, 4, 10, 0, 7, 6, 3, 9, 2, 8, 11},
    '{13, 11, 7, 14, 12, 1, 3, 9, 5, 0, 15, 4, 8, 6, 2, 10},
    '{6, 15, 14, 9, 11, 3, 0, 8, 12, 2, 13, 7, 1, 4, 10, 5},
    '{10, 2, 8, 4, 7, 6, 1, 5, 15, 11, 9, 14, 3, 12, 13, 0}};

  localparam int GI [8][4] = '{
    '{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
    '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [639:0] work = '0;
  logic [63:0] target = '0;
  logic valid = 1'b0;
  logic busy, found;
  logic [31:0] nonce;
`ifdef SIACORE_HASHCNT_EN
  logic [31:0] hash_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] last_nonce = '0;

  always #5 clk = ~clk;

  sia_miner_core #(.ROUNDS(ROUNDS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .work(work),
    .target(target),
    .valid(valid),
    .busy(busy),
    .found(found),
    .nonce(nonce)
`ifdef SIACORE_HASHCNT_EN
    , .hash_cnt(hash_cnt)
`endif
  );

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // digest bytes 0..7 as a big-endian number, header hashed with counter n
  function automatic logic [63:0] ref_hash(input logic [639:0] w, input logic [31:0] n);
    logic [63:0] m [16];
    logic [63:0] v [16];
    logic [63:0] a, b, c, d, h0, d0, res;
    int pa, pb, pc, pd;
    for (int i = 0; i < 16; i++) m[i] = '0;
    for (int i = 0; i < 10; i++)
      for (int bt = 0; bt < 8; bt++)
        m[i][8*bt +: 8] = w[639 - 8*(8*i + bt) -: 8];
    m[4][31:0] = n;
    for (int i = 0; i < 8; i++) begin
      v[i] = IVT[i];
      v[i+8] = IVT[i];
    end
    v[0] = v[0] ^ 64'h0101_0020;
    h0 = v[0];
    v[12] = v[12] ^ 64'd80;
    v[14] = ~v[14];
    for (int r = 0; r < ROUNDS; r++)
      for (int g = 0; g < 8; g++) begin
        pa = GI[g][0]; pb = GI[g][1]; pc = GI[g][2]; pd = GI[g][3];
        a = v[pa] + v[pb] + m[SIG[r%10][2*g]];
        d = rotr64(v[pd] ^ a, 32);
        c = v[pc] + d;
        b = rotr64(v[pb] ^ c, 24);
        a = a + b + m[SIG[r%10][2*g+1]];
        d = rotr64(d ^ a, 16);
        c = c + d;
        b = rotr64(b ^ c, 63);
        v[pa] = a; v[pb] = b; v[pc] = c; v[pd] = d;
      end
    d0 = h0 ^ v[0] ^ v[8];
    for (int k = 0; k < 8; k++) res[63 - 8*k -: 8] = d0[8*k +: 8];
    return res;
  endfunction

  function automatic logic [31:0] swap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [639:0] rand_work();
    logic [639:0] w;
    for (int i = 0; i < 20; i++) w[32*i +: 32] = $urandom();
    return w;
  endfunction

  // counter value s lands in bytes 32..35 little-endian
  function automatic logic [639:0] with_seed(input logic [639:0] w, input logic [31:0] s);
    logic [639:0] r;
    r = w;
    r[383:352] = swap32(s);
    return r;
  endfunction

  task automatic start(input logic [639:0] w, input logic [63:0] t);
    work = w;
    target = t;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic run_search(output int cyc, output logic got);
    cyc = 0;
    got = 1'b0;
    while (cyc < 20 * LAT) begin
      @(posedge clk); #1;
      cyc++;
      if (found) begin
        got = 1'b1;
        break;
      end
      if (!busy) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (found !== 1'b0) begin n_fail++; $display("FAIL reset_found: got %b want 0", found); end
    n_checks++;
    if (nonce !== 32'h0) begin n_fail++; $display("FAIL reset_nonce: got %h want 0", nonce); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_max_target();
    logic [639:0] w;
    int cyc;
    logic got;
    w = rand_work();
    w[383:352] = 32'h1234_5678;
    start(w, 64'hFFFF_FFFF_FFFF_FFFF);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL max_busy_start: got %b want 1", busy); end
    run_search(cyc, got);
    n_checks++;
    if (got !== 1'b1) begin n_fail++; $display("FAIL max_found: got %b want 1", got); end
    n_checks++;
    if (cyc != LAT) begin n_fail++; $display("FAIL max_latency: got %0d want %0d", cyc, LAT); end
    n_checks++;
    if (nonce !== 32'h1234_5678) begin n_fail++; $display("FAIL max_nonce: got %h want 12345678", nonce); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL max_busy_drop: got %b want 0", busy); end
    last_nonce = 32'h1234_5678;
    @(posedge clk); #1;
    n_checks++;
    if (found !== 1'b0) begin n_fail++; $display("FAIL max_pulse_width: got %b want 0", found); end
  endtask

  task automatic test_golden();
    logic [639:0] w;
    logic [63:0] hs [10];
    logic [63:0] t;
    logic [31:0] s;
    int k, j, cyc;
    logic got;
    for (int it = 0; it < 4; it++) begin
      w = rand_work();
      s = $urandom_range(32'hFFFF_0000, 0);
      for (int i = 0; i < 10; i++) hs[i] = ref_hash(w, s + 32'(i));
      k = $urandom_range(9, 0);
      t = hs[k] + 64'd1;
      j = -1;
      for (int i = 0; i < 10; i++)
        if (j < 0 && hs[i] < t) j = i;
      if (j < 0) begin
        t = 64'hFFFF_FFFF_FFFF_FFFF;
        j = 0;
      end
      start(with_seed(w, s), t);
      run_search(cyc, got);
      n_checks++;
      if (got !== 1'b1) begin n_fail++; $display("FAIL golden%0d_found: got %b want 1", it, got); end
      n_checks++;
      if (cyc != (j + 1) * LAT) begin
        n_fail++;
        $display("FAIL golden%0d_latency: got %0d want %0d", it, cyc, (j + 1) * LAT);
      end
      n_checks++;
      if (nonce !== swap32(s + 32'(j))) begin
        n_fail++;
        $display("FAIL golden%0d_nonce: got %h want %h", it, nonce, swap32(s + 32'(j)));
      end
      last_nonce = swap32(s + 32'(j));
      @(posedge clk); #1;
    end
  endtask

  task automatic test_busy_valid();
    logic [639:0] w;
    logic [63:0] hs [4];
    logic [63:0] t;
    logic [31:0] s;
    int j, cyc;
    logic got;
    w = rand_work();
    s = $urandom_range(32'hFFFF_0000, 0);
    for (int i = 0; i < 4; i++) hs[i] = ref_hash(w, s + 32'(i));
    t = hs[2] + 64'd1;
    j = 2;
    for (int i = 1; i >= 0; i--)
      if (hs[i] < t) j = i;
    start(with_seed(w, s), t);
    cyc = 0;
    got = 1'b0;
    while (cyc < 10 * LAT) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 10) begin
        work = rand_work();
        target = 64'hFFFF_FFFF_FFFF_FFFF;
        valid = 1'b1;
      end
      if (cyc == 15) valid = 1'b0;
      if (found) begin got = 1'b1; break; end
      if (!busy) break;
    end
    n_checks++;
    if (got !== 1'b1) begin n_fail++; $display("FAIL busyvalid_found: got %b want 1", got); end
    n_checks++;
    if (cyc != (j + 1) * LAT) begin
      n_fail++;
      $display("FAIL busyvalid_latency: got %0d want %0d", cyc, (j + 1) * LAT);
    end
    n_checks++;
    if (nonce !== swap32(s + 32'(j))) begin
      n_fail++;
      $display("FAIL busyvalid_nonce: got %h want %h", nonce, swap32(s + 32'(j)));
    end
    last_nonce = swap32(s + 32'(j));
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] na, nb;
    int cyc;
    logic got;
    na = $urandom();
    nb = $urandom();
    start(with_seed(rand_work(), swap32(na)), 64'hFFFF_FFFF_FFFF_FFFF);
    run_search(cyc, got);
    n_checks++;
    if (got !== 1'b1 || nonce !== na) begin
      n_fail++;
      $display("FAIL b2b_first: got found=%b nonce=%h want 1 %h", got, nonce, na);
    end
    start(with_seed(rand_work(), swap32(nb)), 64'hFFFF_FFFF_FFFF_FFFF);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b want 1", busy); end
    run_search(cyc, got);
    n_checks++;
    if (got !== 1'b1) begin n_fail++; $display("FAIL b2b_found: got %b want 1", got); end
    n_checks++;
    if (cyc != LAT) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", cyc, LAT); end
    n_checks++;
    if (nonce !== nb) begin n_fail++; $display("FAIL b2b_nonce: got %h want %h", nonce, nb); end
    last_nonce = nb;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int cyc;
    logic got;
    start(with_seed(rand_work(), 32'hFFFF_FFFF), 64'h0);
    run_search(cyc, got);
    n_checks++;
    if (got !== 1'b0) begin n_fail++; $display("FAIL wrap_found: got %b want 0", got); end
    n_checks++;
    if (cyc != LAT || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_idle: got cycle %0d busy %b want %0d 0", cyc, busy, LAT);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (found !== 1'b0 || nonce !== last_nonce) begin
      n_fail++;
      $display("FAIL wrap_after: got found=%b nonce=%h want 0 %h", found, nonce, last_nonce);
    end
  endtask

  task automatic test_miss_abort();
    logic saw_found, saw_idle, nonce_moved;
    saw_found = 1'b0;
    saw_idle = 1'b0;
    nonce_moved = 1'b0;
    start(with_seed(rand_work(), $urandom_range(32'hFFFF_0000, 0)), 64'h0);
    for (int i = 0; i < 3 * LAT + 40; i++) begin
      @(posedge clk); #1;
      if (found) saw_found = 1'b1;
      if (!busy) saw_idle = 1'b1;
      if (nonce !== last_nonce) nonce_moved = 1'b1;
    end
    n_checks++;
    if (saw_found !== 1'b0) begin n_fail++; $display("FAIL miss_found: got %b want 0", saw_found); end
    n_checks++;
    if (saw_idle !== 1'b0) begin n_fail++; $display("FAIL miss_busy_dropped: got %b want 0", saw_idle); end
    n_checks++;
    if (nonce_moved !== 1'b0) begin n_fail++; $display("FAIL miss_nonce_hold: got %b want 0", nonce_moved); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || found !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_flags: got busy=%b found=%b want 0 0", busy, found);
    end
    n_checks++;
    if (nonce !== 32'h0) begin n_fail++; $display("FAIL abort_nonce: got %h want 0", nonce); end
    last_nonce = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw_found = 1'b0;
    saw_idle = 1'b1;
    for (int i = 0; i < LAT + 5; i++) begin
      @(posedge clk); #1;
      if (found) saw_found = 1'b1;
      if (busy) saw_idle = 1'b0;
    end
    n_checks++;
    if (saw_found !== 1'b0 || saw_idle !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_quiet: got found=%b idle=%b want 0 1", saw_found, saw_idle);
    end
  endtask

  initial begin
    test_reset();
    test_max_target();
    test_golden();
    test_busy_valid();
    test_back_to_back();
    test_wrap();
    test_miss_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
